// File: rtl/pll_reset_ctrl.sv
// PLL supervisor in the refclk domain: pulses the PLL reset, qualifies lock,
// and holds the system reset until lock has been stable for a programmable time.
module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0]    RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] loss_reg, loss_next;
  logic [CNT_W-1:0] retry_reg, retry_next;
  logic             sync1_reg, lk_s_reg;
  logic             loss_inc, retry_inc;

  // pll_locked is asynchronous to refclk; two flops before anything looks at it.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      lk_s_reg  <= 1'b0;
    end else begin
      sync1_reg <= pll_locked;
      lk_s_reg  <= sync1_reg;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg <= PLL_RESET;
      cnt_reg   <= '0;
      loss_reg  <= '0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      loss_reg  <= loss_next;
      retry_reg <= retry_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_inc   = 1'b0;
    retry_inc  = 1'b0;
    case (state_reg)
      PLL_RESET: begin
        if (cnt_reg == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the very last timeout cycle still wins over a retry.
        if (lk_s_reg) begin
          state_next = STABILIZE;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          state_next = PLL_RESET;
          cnt_next   = '0;
          retry_inc  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STABILIZE: begin
        if (!lk_s_reg) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STAB_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lk_s_reg) begin
          state_next = PLL_RESET;
          loss_inc   = 1'b1;
        end
      end
      default: begin
        state_next = PLL_RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // Saturating event counters; a clear in the same cycle beats an increment.
  always_comb begin
    loss_next  = loss_reg;
    retry_next = retry_reg;
    if (clear_counts) begin
      loss_next  = '0;
      retry_next = '0;
    end else begin
      if (loss_inc && (loss_reg != CNT_MAX))
        loss_next = loss_reg + CNT_W'(1);
      if (retry_inc && (retry_reg != CNT_MAX))
        retry_next = retry_reg + CNT_W'(1);
    end
  end

  assign pll_rst     = (state_reg == PLL_RESET);
  assign sys_rst     = (state_reg != RUN);
  assign ready       = (state_reg == RUN);
  assign state       = state_reg;
  assign loss_count  = loss_reg;
  assign retry_count = retry_reg;

endmodule
